// File: rtl/spike_router_pkg.sv
// Shared definitions for the spike mesh router: packet layout, port indices,
// local delivery word and the round-robin pick helper.
package spike_router_pkg;

  localparam int unsigned PKT_W    = 26;
  localparam int unsigned COORD_W  = 9;
  localparam int unsigned AXON_W   = 8;
  localparam int unsigned DX_MSB   = 25;
  localparam int unsigned DX_LSB   = 17;
  localparam int unsigned DY_MSB   = 16;
  localparam int unsigned DY_LSB   = 8;
  localparam int unsigned AXON_MSB = 7;
  localparam int unsigned AXON_LSB = 0;

  localparam int unsigned TICK_W   = 4;
  localparam int unsigned DEBUG_W  = 2;
  localparam int unsigned LOCAL_W  = AXON_W + TICK_W + DEBUG_W;

  localparam int unsigned NPORTS   = 5;
  localparam int unsigned PORT_W   = 3;

  typedef enum logic [PORT_W-1:0] {
    P_LOCAL = 3'd0,
    P_NORTH = 3'd1,
    P_SOUTH = 3'd2,
    P_EAST  = 3'd3,
    P_WEST  = 3'd4
  } port_e;

  typedef struct packed {
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [AXON_W-1:0]  axon;
  } pkt_t;

  typedef struct packed {
    logic [AXON_W-1:0]  axon;
    logic [TICK_W-1:0]  delivery_tick;
    logic [DEBUG_W-1:0] debug;
  } local_word_t;

  // Tick and debug are not carried by mesh packets, so they are always zero.
  function automatic local_word_t to_local_word(input logic [AXON_W-1:0] axon);
    local_word_t w;
    w.axon          = axon;
    w.delivery_tick = '0;
    w.debug         = '0;
    return w;
  endfunction

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [PORT_W:0] rr_pick(input logic [NPORTS-1:0] req,
                                              input logic [PORT_W-1:0] ptr);
    logic [PORT_W-1:0] idx;
    logic [PORT_W:0]   res;
    res = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = PORT_W'((32'(ptr) + 32'(k)) % NPORTS);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/router_in_port.sv
// One router input: single-entry buffer plus the X-then-Y route decision and
// coordinate update for the buffered packet.
module router_in_port
  import spike_router_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             req_valid,
  output port_e            req_port,
  output pkt_t             fwd_data,
  input  logic             grant
);

  logic full_q, full_d;
  pkt_t buf_q, buf_d;

  assign in_ready  = !full_q;
  assign req_valid = full_q;

  // Capture and grant are exclusive: grant needs a full buffer, capture an empty one.
  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      buf_d  = pkt_t'(in_data);
    end else if (grant) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
    end
  end

  // Step one hop toward zero offset, resolving X before Y.
  always_comb begin
    fwd_data = buf_q;
    req_port = P_LOCAL;
    if (buf_q.dx != '0) begin
      if (buf_q.dx[COORD_W-1]) begin
        req_port    = P_WEST;
        fwd_data.dx = buf_q.dx + COORD_W'(1);
      end else begin
        req_port    = P_EAST;
        fwd_data.dx = buf_q.dx - COORD_W'(1);
      end
    end else if (buf_q.dy != '0) begin
      if (buf_q.dy[COORD_W-1]) begin
        req_port    = P_SOUTH;
        fwd_data.dy = buf_q.dy + COORD_W'(1);
      end else begin
        req_port    = P_NORTH;
        fwd_data.dy = buf_q.dy - COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/spike_router.sv
// Five-port dimension-order spike router: per-input buffers, per-output
// round-robin arbitration, output registers and stall timeout detection.
module spike_router
  import spike_router_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PKT_W-1:0]   local_in_data,
  input  logic               local_in_valid,
  output logic               local_in_ready,
  output logic [LOCAL_W-1:0] local_out_data,
  output logic               local_out_valid,
  input  logic               local_out_ready,
  input  logic [PKT_W-1:0]   north_in_data,
  input  logic               north_in_valid,
  output logic               north_in_ready,
  output logic [PKT_W-1:0]   north_out_data,
  output logic               north_out_valid,
  input  logic               north_out_ready,
  input  logic [PKT_W-1:0]   south_in_data,
  input  logic               south_in_valid,
  output logic               south_in_ready,
  output logic [PKT_W-1:0]   south_out_data,
  output logic               south_out_valid,
  input  logic               south_out_ready,
  input  logic [PKT_W-1:0]   east_in_data,
  input  logic               east_in_valid,
  output logic               east_in_ready,
  output logic [PKT_W-1:0]   east_out_data,
  output logic               east_out_valid,
  input  logic               east_out_ready,
  input  logic [PKT_W-1:0]   west_in_data,
  input  logic               west_in_valid,
  output logic               west_in_ready,
  output logic [PKT_W-1:0]   west_out_data,
  output logic               west_out_valid,
  input  logic               west_out_ready,
  output logic               timeout_error,
  output logic [PORT_W-1:0]  error_source
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NPORTS-1:0][PKT_W-1:0]  in_data;
  logic [NPORTS-1:0]             in_valid, in_ready, req_valid, grant, out_ready;
  logic [NPORTS-1:0][PORT_W-1:0] req_port;
  pkt_t [NPORTS-1:0]             fwd_data;
  logic [NPORTS-1:0][NPORTS-1:0] req_mask;
  logic [NPORTS-1:0][PORT_W:0]   pick_res;
  logic [NPORTS-1:0][PORT_W-1:0] win;
  logic [NPORTS-1:0]             load;

  logic [NPORTS-1:0]             out_valid_q, out_valid_d;
  pkt_t [NPORTS-1:1]             nb_data_q, nb_data_d;
  logic [AXON_W-1:0]             loc_axon_q, loc_axon_d;
  logic [NPORTS-1:0][PORT_W-1:0] ptr_q, ptr_d;
  logic [NPORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                          err_q, err_d;
  logic [PORT_W-1:0]             src_q, src_d;

  assign in_data   = {west_in_data, east_in_data, south_in_data, north_in_data, local_in_data};
  assign in_valid  = {west_in_valid, east_in_valid, south_in_valid, north_in_valid, local_in_valid};
  assign out_ready = {west_out_ready, east_out_ready, south_out_ready, north_out_ready,
                      local_out_ready};

  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    port_e port_sel;
    router_in_port u_in (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data[i]),
      .in_valid (in_valid[i]),
      .in_ready (in_ready[i]),
      .req_valid(req_valid[i]),
      .req_port (port_sel),
      .fwd_data (fwd_data[i]),
      .grant    (grant[i])
    );
    assign req_port[i] = port_sel;
  end

  always_comb begin
    req_mask = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        req_mask[o][i] = req_valid[i] && (req_port[i] == PORT_W'(o));
      end
    end
  end

  // An output may load when empty or when its current word drains this cycle.
  always_comb begin
    pick_res    = '0;
    win         = '0;
    load        = '0;
    grant       = '0;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    for (int o = 0; o < NPORTS; o++) begin
      pick_res[o] = rr_pick(req_mask[o], ptr_q[o]);
      win[o]      = pick_res[o][PORT_W-1:0];
      load[o]     = pick_res[o][PORT_W] && (!out_valid_q[o] || out_ready[o]);
      if (out_valid_q[o] && out_ready[o]) out_valid_d[o] = 1'b0;
      if (load[o]) begin
        out_valid_d[o]   = 1'b1;
        grant[win[o]]    = 1'b1;
        ptr_d[o]         = (win[o] == PORT_W'(NPORTS - 1)) ? '0 : win[o] + PORT_W'(1);
      end
    end
  end

  always_comb begin
    nb_data_d  = nb_data_q;
    loc_axon_d = loc_axon_q;
    if (load[P_LOCAL]) loc_axon_d = fwd_data[win[P_LOCAL]].axon;
    for (int o = 1; o < NPORTS; o++) begin
      if (load[o]) nb_data_d[o] = fwd_data[win[o]];
    end
  end

  // Stall counters saturate at the limit; the lowest saturated port is reported.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    src_d = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (!out_valid_q[o] || out_ready[o]) begin
        cnt_d[o] = '0;
      end else if (cnt_q[o] != CNT_W'(TIMEOUT_CYCLES)) begin
        cnt_d[o] = cnt_q[o] + CNT_W'(1);
      end
    end
    for (int o = NPORTS - 1; o >= 0; o--) begin
      if (cnt_d[o] == CNT_W'(TIMEOUT_CYCLES)) begin
        err_d = 1'b1;
        src_d = PORT_W'(o);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= '0;
      nb_data_q   <= '0;
      loc_axon_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      src_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      nb_data_q   <= nb_data_d;
      loc_axon_q  <= loc_axon_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      src_q       <= src_d;
    end
  end

  assign local_in_ready  = in_ready[P_LOCAL];
  assign north_in_ready  = in_ready[P_NORTH];
  assign south_in_ready  = in_ready[P_SOUTH];
  assign east_in_ready   = in_ready[P_EAST];
  assign west_in_ready   = in_ready[P_WEST];

  assign local_out_valid = out_valid_q[P_LOCAL];
  assign north_out_valid = out_valid_q[P_NORTH];
  assign south_out_valid = out_valid_q[P_SOUTH];
  assign east_out_valid  = out_valid_q[P_EAST];
  assign west_out_valid  = out_valid_q[P_WEST];

  assign local_out_data  = to_local_word(loc_axon_q);
  assign north_out_data  = nb_data_q[P_NORTH];
  assign south_out_data  = nb_data_q[P_SOUTH];
  assign east_out_data   = nb_data_q[P_EAST];
  assign west_out_data   = nb_data_q[P_WEST];

  assign timeout_error   = err_q;
  assign error_source    = src_q;

endmodule

// File: tb/tb_spike_router.sv
// Directed bench for spike_router: routing, contention, backpressure,
// stall timeout and reset behaviour with hand-computed expectations.
module tb_spike_router;

  localparam int unsigned T = 16;

  logic        clk;
  logic        rst;
  logic [25:0] local_in_data, north_in_data, south_in_data, east_in_data, west_in_data;
  logic        local_in_valid, north_in_valid, south_in_valid, east_in_valid, west_in_valid;
  logic        local_in_ready, north_in_ready, south_in_ready, east_in_ready, west_in_ready;
  logic [13:0] local_out_data;
  logic [25:0] north_out_data, south_out_data, east_out_data, west_out_data;
  logic        local_out_valid, north_out_valid, south_out_valid, east_out_valid, west_out_valid;
  logic        local_out_ready, north_out_ready, south_out_ready, east_out_ready, west_out_ready;
  logic        timeout_error;
  logic [2:0]  error_source;

  int checks   = 0;
  int failures = 0;

  spike_router #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .local_in_data(local_in_data), .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
    .local_out_data(local_out_data), .local_out_valid(local_out_valid),
    .local_out_ready(local_out_ready),
    .north_in_data(north_in_data), .north_in_valid(north_in_valid), .north_in_ready(north_in_ready),
    .north_out_data(north_out_data), .north_out_valid(north_out_valid),
    .north_out_ready(north_out_ready),
    .south_in_data(south_in_data), .south_in_valid(south_in_valid), .south_in_ready(south_in_ready),
    .south_out_data(south_out_data), .south_out_valid(south_out_valid),
    .south_out_ready(south_out_ready),
    .east_in_data(east_in_data), .east_in_valid(east_in_valid), .east_in_ready(east_in_ready),
    .east_out_data(east_out_data), .east_out_valid(east_out_valid),
    .east_out_ready(east_out_ready),
    .west_in_data(west_in_data), .west_in_valid(west_in_valid), .west_in_ready(west_in_ready),
    .west_out_data(west_out_data), .west_out_valid(west_out_valid),
    .west_out_ready(west_out_ready),
    .timeout_error(timeout_error), .error_source(error_source)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-hop table: input offsets, expected output port and forwarded offsets.
  int hop_dx   [5] = '{5, -3, 0, 0, 0};
  int hop_dy   [5] = '{0, 0, 4, -2, 0};
  int hop_axon [5] = '{'h42, 'h43, 'h44, 'h45, 'h46};
  int hop_port [5] = '{3, 4, 1, 2, 0};
  int hop_edx  [5] = '{4, -2, 0, 0, 0};
  int hop_edy  [5] = '{0, 0, 3, -1, 0};

  function automatic logic [25:0] mk(input int dx, input int dy, input int axon);
    return {9'(dx), 9'(dy), 8'(axon)};
  endfunction

  function automatic logic out_v(input int p);
    case (p)
      0: return local_out_valid;
      1: return north_out_valid;
      2: return south_out_valid;
      3: return east_out_valid;
      4: return west_out_valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [25:0] out_d(input int p);
    case (p)
      0: return {12'd0, local_out_data};
      1: return north_out_data;
      2: return south_out_data;
      3: return east_out_data;
      4: return west_out_data;
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_ready(input logic r);
    local_out_ready = r; north_out_ready = r; south_out_ready = r;
    east_out_ready  = r; west_out_ready  = r;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] v, r;
    do_reset();
    v = {west_out_valid, east_out_valid, south_out_valid, north_out_valid, local_out_valid};
    r = {west_in_ready, east_in_ready, south_in_ready, north_in_ready, local_in_ready};
    checks++;
    if (v !== 5'b00000) begin failures++; $display("FAIL reset_out_valid got=%b exp=00000", v); end
    checks++;
    if (r !== 5'b11111) begin failures++; $display("FAIL reset_in_ready got=%b exp=11111", r); end
    checks++;
    if (timeout_error !== 1'b0 || error_source !== 3'd0) begin
      failures++;
      $display("FAIL reset_timeout got=%b/%0d exp=0/0", timeout_error, error_source);
    end
    checks++;
    if ({local_out_data, east_out_data, west_out_data, north_out_data, south_out_data} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0", local_out_data, east_out_data);
    end
  endtask

  task automatic test_single_hop();
    logic [25:0] exp;
    int          others;
    all_ready(1'b1);
    for (int i = 0; i < 5; i++) begin
      local_in_data  = mk(hop_dx[i], hop_dy[i], hop_axon[i]);
      local_in_valid = 1'b1;
      step();
      local_in_valid = 1'b0;
      step();
      exp = (hop_port[i] == 0) ? {12'd0, 8'(hop_axon[i]), 6'd0}
                               : mk(hop_edx[i], hop_edy[i], hop_axon[i]);
      checks++;
      if (out_v(hop_port[i]) !== 1'b1) begin
        failures++; $display("FAIL hop%0d_valid port=%0d got=%b exp=1", i, hop_port[i], out_v(hop_port[i]));
      end
      checks++;
      if (out_d(hop_port[i]) !== exp) begin
        failures++; $display("FAIL hop%0d_data got=%h exp=%h", i, out_d(hop_port[i]), exp);
      end
      others = 0;
      for (int p = 0; p < 5; p++) if (p != hop_port[i] && out_v(p) === 1'b1) others++;
      checks++;
      if (others !== 0) begin failures++; $display("FAIL hop%0d_stray got=%0d exp=0", i, others); end
      step();
    end
  endtask

  task automatic test_x_first();
    all_ready(1'b1);
    local_in_data  = mk(2, 3, 'h47);
    local_in_valid = 1'b1;
    step();
    local_in_valid = 1'b0;
    step();
    checks++;
    if (east_out_valid !== 1'b1 || east_out_data !== mk(1, 3, 'h47)) begin
      failures++; $display("FAIL xfirst_east got=%b/%h exp=1/%h", east_out_valid, east_out_data, mk(1, 3, 'h47));
    end
    checks++;
    if (north_out_valid !== 1'b0) begin failures++; $display("FAIL xfirst_north got=%b exp=0", north_out_valid); end
    step();
  endtask

  task automatic test_contention();
    do_reset();
    all_ready(1'b1);
    local_in_data = mk(1, 0, 'h50);  local_in_valid = 1'b1;
    north_in_data = mk(0, -1, 'h51); north_in_valid = 1'b1;
    south_in_data = mk(0, 1, 'h52);  south_in_valid = 1'b1;
    east_in_data  = mk(-1, 0, 'h53); east_in_valid  = 1'b1;
    west_in_data  = mk(1, 0, 'h54);  west_in_valid  = 1'b1;
    step();
    {local_in_valid, north_in_valid, south_in_valid, east_in_valid, west_in_valid} = '0;
    step();
    checks++;
    if (east_out_valid !== 1'b1 || east_out_data !== mk(0, 0, 'h50)) begin
      failures++; $display("FAIL cont_east_first got=%b/%h exp=1/%h", east_out_valid, east_out_data, mk(0, 0, 'h50));
    end
    checks++;
    if (south_out_valid !== 1'b1 || south_out_data !== mk(0, 0, 'h51)) begin
      failures++; $display("FAIL cont_south got=%b/%h exp=1/%h", south_out_valid, south_out_data, mk(0, 0, 'h51));
    end
    checks++;
    if (north_out_valid !== 1'b1 || north_out_data !== mk(0, 0, 'h52)) begin
      failures++; $display("FAIL cont_north got=%b/%h exp=1/%h", north_out_valid, north_out_data, mk(0, 0, 'h52));
    end
    checks++;
    if (west_out_valid !== 1'b1 || west_out_data !== mk(0, 0, 'h53)) begin
      failures++; $display("FAIL cont_west got=%b/%h exp=1/%h", west_out_valid, west_out_data, mk(0, 0, 'h53));
    end
    checks++;
    if (west_in_ready !== 1'b0) begin failures++; $display("FAIL cont_loser_held got=%b exp=0", west_in_ready); end
    step();
    checks++;
    if (east_out_valid !== 1'b1 || east_out_data !== mk(0, 0, 'h54)) begin
      failures++; $display("FAIL cont_east_second got=%b/%h exp=1/%h", east_out_valid, east_out_data, mk(0, 0, 'h54));
    end
    checks++;
    if ({north_out_valid, south_out_valid, west_out_valid, local_out_valid} !== 4'b0000) begin
      failures++; $display("FAIL cont_no_dup got=%b exp=0000",
                           {north_out_valid, south_out_valid, west_out_valid, local_out_valid});
    end
    step();
    checks++;
    if (east_out_valid !== 1'b0) begin failures++; $display("FAIL cont_east_drained got=%b exp=0", east_out_valid); end
  endtask

  task automatic test_backpressure();
    all_ready(1'b1);
    east_out_ready = 1'b0;
    local_in_data  = mk(3, 0, 'h4A);
    local_in_valid = 1'b1;
    step();
    local_in_data  = mk(1, 0, 'h4B);
    step();
    checks++;
    if (east_out_valid !== 1'b1 || east_out_data !== mk(2, 0, 'h4A)) begin
      failures++; $display("FAIL bp_first got=%b/%h exp=1/%h", east_out_valid, east_out_data, mk(2, 0, 'h4A));
    end
    step();
    local_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (east_out_valid !== 1'b1 || east_out_data !== mk(2, 0, 'h4A) || local_in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/%h/0", c, east_out_valid, east_out_data,
                             local_in_ready, mk(2, 0, 'h4A));
      end
    end
    east_out_ready = 1'b1;
    step();
    checks++;
    if (east_out_valid !== 1'b1 || east_out_data !== mk(0, 0, 'h4B) || local_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_second got=%b/%h/%b exp=1/%h/1", east_out_valid, east_out_data,
                           local_in_ready, mk(0, 0, 'h4B));
    end
    step();
    checks++;
    if (east_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", east_out_valid); end
  endtask

  task automatic test_timeout();
    all_ready(1'b0);
    local_in_data  = mk(1, 0, 'h60);
    local_in_valid = 1'b1;
    step();
    local_in_valid = 1'b0;
    step();
    repeat (T - 1) step();
    checks++;
    if (timeout_error !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", timeout_error); end
    step();
    checks++;
    if (timeout_error !== 1'b1 || error_source !== 3'd3) begin
      failures++; $display("FAIL to_raise got=%b/%0d exp=1/3", timeout_error, error_source);
    end
    repeat (3) step();
    checks++;
    if (timeout_error !== 1'b1 || error_source !== 3'd3 || east_out_valid !== 1'b1 ||
        east_out_data !== mk(0, 0, 'h60)) begin
      failures++; $display("FAIL to_hold got=%b/%0d/%b/%h exp=1/3/1/%h", timeout_error, error_source,
                           east_out_valid, east_out_data, mk(0, 0, 'h60));
    end
    east_out_ready = 1'b1;
    step();
    checks++;
    if (timeout_error !== 1'b0 || error_source !== 3'd0 || east_out_valid !== 1'b0) begin
      failures++; $display("FAIL to_clear got=%b/%0d/%b exp=0/0/0", timeout_error, error_source, east_out_valid);
    end
    all_ready(1'b1);
  endtask

  task automatic test_reset_midflight();
    logic [4:0] v, r;
    logic       ghost;
    all_ready(1'b1);
    east_out_ready = 1'b0;
    local_in_data  = mk(1, 0, 'h70);
    local_in_valid = 1'b1;
    step();
    local_in_data  = mk(2, 0, 'h72);
    step();
    step();
    local_in_valid = 1'b0;
    checks++;
    if (east_out_valid !== 1'b1 || local_in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_setup got=%b/%b exp=1/0", east_out_valid, local_in_ready);
    end
    do_reset();
    v = {west_out_valid, east_out_valid, south_out_valid, north_out_valid, local_out_valid};
    r = {west_in_ready, east_in_ready, south_in_ready, north_in_ready, local_in_ready};
    checks++;
    if (v !== 5'b00000 || r !== 5'b11111 || east_out_data !== 26'd0) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%h exp=00000/11111/0", v, r, east_out_data);
    end
    east_out_ready = 1'b1;
    ghost = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      ghost = ghost | east_out_valid;
    end
    checks++;
    if (ghost !== 1'b0) begin failures++; $display("FAIL mid_ghost got=%b exp=0", ghost); end
  endtask

  initial begin
    rst = 1'b1;
    {local_in_valid, north_in_valid, south_in_valid, east_in_valid, west_in_valid} = '0;
    local_in_data = '0; north_in_data = '0; south_in_data = '0; east_in_data = '0; west_in_data = '0;
    all_ready(1'b1);
    step();
    test_reset();
    test_single_hop();
    test_x_first();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
